// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Runs a binary counter for a requested number of steps, up or down, and
//   presents the count as registered Gray code. A run can be paused and
//   resumed, or aborted. The count is kept between runs.
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   start     begin a run (sampled only when idle)
//   len[N]    number of steps in the run (sampled with start)
//   dir       0 = count up, 1 = count down (sampled with start)
//   pause     hold the count while high during a run
//   stop      abort the current run
//   gray_out  registered Gray code of the internal binary count
//   busy      high while a run is active or paused
//   done      one-cycle pulse after the last step of a full run
//   wrap      one-cycle pulse after a step that wrapped the count
//   remain[N] steps still outstanding in the current run
//   err       sticky Gray-code integrity flag
//
// Build option
//   GRAY_SEQ_CHECK_EN  when defined, err latches if gray_out ever changes by
//                      more than one bit between clocks; otherwise err is 0.
module gray_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] len,
  input  logic         dir,
  input  logic         pause,
  input  logic         stop,
  output logic [N-1:0] gray_out,
  output logic         busy,
  output logic         done,
  output logic         wrap,
  output logic [N-1:0] remain,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state, state_d;
  logic [N-1:0] bin;
  logic [N-1:0] bin_nxt;
  logic         dir_q;
  logic         load, step, clr;
  logic         wrap_nxt;

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [N-1:0] bin_step(input logic [N-1:0] b, input logic down);
    return down ? (b - ONE) : (b + ONE);
  endfunction

  assign bin_nxt  = bin_step(bin, dir_q);
  assign wrap_nxt = dir_q ? (bin == '0) : (bin == '1);

  // next-state decode; stop outranks pause, and both outrank the step
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    clr     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (stop) begin
          clr     = 1'b1;
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          step = 1'b1;
          if (remain == ONE) state_d = DONE;
        end
      end
      PAUSE: begin
        if (stop) begin
          clr     = 1'b1;
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, count and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bin      <= '0;
      gray_out <= '0;
      dir_q    <= 1'b0;
      remain   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == RUN) || (state_d == PAUSE);
      done  <= (state_d == DONE);
      wrap  <= 1'b0;
      if (load) begin
        remain <= len;
        dir_q  <= dir;
      end else if (clr) begin
        remain <= '0;
      end else if (step) begin
        remain   <= remain - ONE;
        bin      <= bin_nxt;
        gray_out <= bin2gray(bin_nxt);
        wrap     <= wrap_nxt;
      end
    end
  end

`ifdef GRAY_SEQ_CHECK_EN
  logic [N-1:0] gray_prev;
  logic [N-1:0] gray_diff;

  assign gray_diff = gray_out ^ gray_prev;

  // more than one bit set <=> clearing the lowest set bit leaves something
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gray_prev <= '0;
      err       <= 1'b0;
    end else begin
      gray_prev <= gray_out;
      if ((gray_diff & (gray_diff - ONE)) != '0) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
module tb_gray_seq_ctrl;

  typedef struct packed {
    logic [3:0] gray;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [3:0] remain;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       dir;
    logic       pause;
    logic       stop;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start, dir, pause, stop;
  logic [3:0] len;
  logic [3:0] gray_out, remain;
  logic       busy, done, wrap, err;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbq[$];
  vec_t tbl[$];
  logic [3:0] mbin;

  gray_seq_ctrl #(.N(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .dir(dir),
    .pause(pause), .stop(stop), .gray_out(gray_out), .busy(busy),
    .done(done), .wrap(wrap), .remain(remain), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty got 0 expected 1 entry", tag);
      return;
    end
    e = sbq.pop_front();
    chk({tag, " gray"},   {4'b0, gray_out}, {4'b0, e.gray});
    chk({tag, " busy"},   {7'b0, busy},     {7'b0, e.busy});
    chk({tag, " done"},   {7'b0, done},     {7'b0, e.done});
    chk({tag, " wrap"},   {7'b0, wrap},     {7'b0, e.wrap});
    chk({tag, " remain"}, {4'b0, remain},   {4'b0, e.remain});
    chk({tag, " err"},    {7'b0, err},      8'd0);
  endtask

  task automatic add(input logic r, input logic s, input logic [3:0] l, input logic d,
                     input logic p, input logic sp, input logic [3:0] g, input logic b,
                     input logic dn, input logic w, input logic [3:0] rm);
    vec_t v;
    v.rst = r; v.start = s; v.len = l; v.dir = d; v.pause = p; v.stop = sp;
    v.e.gray = g; v.e.busy = b; v.e.done = dn; v.e.wrap = w; v.e.remain = rm;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic s, input logic [3:0] l, input logic d,
                       input logic p, input logic sp);
    start = s; len = l; dir = d; pause = p; stop = sp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    mbin = 4'd0;
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    logic [3:0] g;
    for (int k = 0; k < 3; k++) g[k] = b[k] ^ b[k+1];
    g[3] = b[3];
    return g;
  endfunction

  // run of l steps in direction d, expectations from the reference count mbin
  task automatic run(input int l, input logic d, input string tag);
    exp_t e;
    logic wr;
    @(negedge clk);
    drive(1'b1, 4'(l), d, 1'b0, 1'b0);
    e = '{gray: to_gray(mbin), busy: (l != 0), done: (l == 0), wrap: 1'b0, remain: 4'(l)};
    sbq.push_back(e);
    @(posedge clk); #1; compare($sformatf("%s start", tag));
    for (int i = 1; i <= l; i++) begin
      @(negedge clk);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      wr   = d ? (mbin == 4'd0) : (mbin == 4'd15);
      mbin = d ? mbin - 4'd1 : mbin + 4'd1;
      e = '{gray: to_gray(mbin), busy: (i < l), done: (i == l), wrap: wr, remain: 4'(l - i)};
      sbq.push_back(e);
      @(posedge clk); #1; compare($sformatf("%s step%0d", tag, i));
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    e = '{gray: to_gray(mbin), busy: 1'b0, done: 1'b0, wrap: 1'b0, remain: 4'd0};
    sbq.push_back(e);
    @(posedge clk); #1; compare($sformatf("%s idle", tag));
  endtask

  task automatic cyc(input logic s, input logic [3:0] l, input logic d, input exp_t e,
                     input string tag);
    @(negedge clk);
    drive(s, l, d, 1'b0, 1'b0);
    sbq.push_back(e);
    @(posedge clk); #1; compare(tag);
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    mbin = 4'd0;

    // len=5 up run, len=0 run, start ignored in DONE, stop/pause ignored in IDLE
    add(1,1,5,0,0,0, 0,1,0,0,5);
    add(0,0,0,0,0,0, 1,1,0,0,4);
    add(0,0,0,0,0,0, 3,1,0,0,3);
    add(0,0,0,0,0,0, 2,1,0,0,2);
    add(0,0,0,0,0,0, 6,1,0,0,1);
    add(0,0,0,0,0,0, 7,0,1,0,0);
    add(0,0,0,0,0,0, 7,0,0,0,0);
    add(0,1,0,0,0,0, 7,0,1,0,0);
    add(0,1,3,0,0,0, 7,0,0,0,0);
    add(0,0,0,0,1,1, 7,0,0,0,0);
    // len=4 with a 3-cycle pause after E2, start ignored while paused
    add(1,1,4,0,0,0, 0,1,0,0,4);
    add(0,0,0,0,0,0, 1,1,0,0,3);
    add(0,0,0,0,0,0, 3,1,0,0,2);
    add(0,0,0,0,1,0, 3,1,0,0,2);
    add(0,1,7,1,1,0, 3,1,0,0,2);
    add(0,0,0,0,1,0, 3,1,0,0,2);
    add(0,0,0,0,0,0, 3,1,0,0,2);
    add(0,0,0,0,0,0, 2,1,0,0,1);
    add(0,0,0,0,0,0, 6,0,1,0,0);
    add(0,0,0,0,0,0, 6,0,0,0,0);
    // len=6 stopped at E3, restart down, stop beats final step, down wrap,
    // stop beats pause in RUN, stop in PAUSE
    add(1,1,6,0,0,0, 0,1,0,0,6);
    add(0,0,0,0,0,0, 1,1,0,0,5);
    add(0,0,0,0,0,0, 3,1,0,0,4);
    add(0,0,0,0,0,1, 3,0,0,0,0);
    add(0,1,2,1,0,0, 3,1,0,0,2);
    add(0,0,0,0,0,0, 1,1,0,0,1);
    add(0,0,0,0,0,0, 0,0,1,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0);
    add(0,1,1,1,0,0, 0,1,0,0,1);
    add(0,0,0,0,0,1, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0);
    add(0,1,1,1,0,0, 0,1,0,0,1);
    add(0,0,0,0,0,0, 8,0,1,1,0);
    add(0,0,0,0,0,0, 8,0,0,0,0);
    add(0,1,2,0,0,0, 8,1,0,0,2);
    add(0,0,0,0,1,1, 8,0,0,0,0);
    add(0,1,2,0,0,0, 8,1,0,0,2);
    add(0,0,0,0,1,0, 8,1,0,0,2);
    add(0,0,0,0,1,1, 8,0,0,0,0);
    add(0,0,0,0,0,0, 8,0,0,0,0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    sbq.push_back('{gray: 4'd0, busy: 1'b0, done: 1'b0, wrap: 1'b0, remain: 4'd0});
    compare("reset");
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
      end
      drive(tbl[i].start, tbl[i].len, tbl[i].dir, tbl[i].pause, tbl[i].stop);
      sbq.push_back(tbl[i].e);
      @(posedge clk); #1;
      compare($sformatf("row%0d", i));
    end

    // count to 14, then a 3-step run across the 15->0 wrap
    do_reset();
    run(14, 1'b0, "to14");
    run(3, 1'b0, "wrap3");
    chk("wrap3 final gray", {4'b0, gray_out}, 8'd1);

    // 40 steps mixing up and down runs with wraps
    run(15, 1'b0, "long_up15");
    run(12, 1'b0, "long_up12");
    run(13, 1'b1, "long_dn13");

    // reset in the middle of a run
    do_reset();
    cyc(1'b1, 4'd5, 1'b0, '{gray: 4'd0, busy: 1'b1, done: 1'b0, wrap: 1'b0, remain: 4'd5}, "mid E0");
    cyc(1'b0, 4'd0, 1'b0, '{gray: 4'd1, busy: 1'b1, done: 1'b0, wrap: 1'b0, remain: 4'd4}, "mid E1");
    cyc(1'b0, 4'd0, 1'b0, '{gray: 4'd3, busy: 1'b1, done: 1'b0, wrap: 1'b0, remain: 4'd3}, "mid E2");
    @(negedge clk);
    rstn = 1'b0;
    #1;
    sbq.push_back('{gray: 4'd0, busy: 1'b0, done: 1'b0, wrap: 1'b0, remain: 4'd0});
    compare("mid async");
    rstn = 1'b1;
    @(posedge clk); #1;
    sbq.push_back('{gray: 4'd0, busy: 1'b0, done: 1'b0, wrap: 1'b0, remain: 4'd0});
    compare("mid after1");
    cyc(1'b0, 4'd0, 1'b0, '{gray: 4'd0, busy: 1'b0, done: 1'b0, wrap: 1'b0, remain: 4'd0}, "mid after2");
    mbin = 4'd0;
    run(1, 1'b0, "mid restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
